lcd_tile_window_gen: RTL

// Parametrised LCD window-coordinate generator. It replaces the fixed 13-entry counter decoder.
// - Produces the packed column window (set_x_o) and row window (set_y_o) consumed by the LCD
//   set-window command sequencer.
// - Modes: full screen, automatic row-major scan of a TILE_COLS x TILE_ROWS grid, or one selected tile.
// - Uses a valid/ack handshake, so the sequencer pulls one window per draw pass.

---
 rtl/lcd_tile_window_gen_if.sv | 29 ++
 rtl/lcd_tile_window_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/lcd_tile_window_gen_if.sv
// Handshake/bus bundle between the LCD window generator and its set-window sequencer.
// The slave modport is the generator side; master is the controlling/consuming side.
interface lcd_tile_window_gen_if #(
    parameter int HALF_W = 32
);
    logic                  start_i;
    logic [1:0]            mode_i;
    logic [7:0]            tile_col_i;
    logic [7:0]            tile_row_i;
    logic                  abort_i;
    logic                  win_ack_i;
    logic                  win_valid_o;
    logic [2*HALF_W-1:0]   set_x_o;
    logic [2*HALF_W-1:0]   set_y_o;
    logic [7:0]            tile_idx_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    modport slave (
        input  start_i, mode_i, tile_col_i, tile_row_i, abort_i, win_ack_i,
        output win_valid_o, set_x_o, set_y_o, tile_idx_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, mode_i, tile_col_i, tile_row_i, abort_i, win_ack_i,
        input  win_valid_o, set_x_o, set_y_o, tile_idx_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/lcd_tile_window_gen.sv
// LCD window-coordinate generator: full screen, row-major scan of a tile grid, or one tile,
// handed to the set-window sequencer one window at a time over a valid/ack handshake.
module lcd_tile_window_gen #(
    parameter int LCD_W     = 240,
    parameter int LCD_H     = 320,
    parameter int TILE_COLS = 3,
    parameter int TILE_ROWS = 4,
    parameter int HALF_W    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    lcd_tile_window_gen_if.slave  win_if
);
    localparam int TILE_W = LCD_W / TILE_COLS;
    localparam int TILE_H = LCD_H / TILE_ROWS;

    typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [7:0]          col_q, col_d;
    logic [7:0]          row_q, row_d;
    logic [2*HALF_W-1:0] set_x_q, set_x_d;
    logic [2*HALF_W-1:0] set_y_q, set_y_d;
    logic [7:0]          idx_q, idx_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [HALF_W-1:0]   x_start, x_end, y_start, y_end;
    logic [7:0]          tile_idx;
    logic                last_col, last_tile, tile_oor;

    // The last column/row absorbs the division remainder so the panel edge is always covered.
    always_comb begin
        x_start = '0;
        x_end   = '0;
        y_start = '0;
        y_end   = '0;
        for (int c = 0; c < TILE_COLS; c++) begin
            if (col_q == 8'(c)) begin
                x_start = HALF_W'(c * TILE_W);
                x_end   = (c == TILE_COLS - 1) ? HALF_W'(LCD_W - 1) : HALF_W'(c * TILE_W + TILE_W - 1);
            end
        end
        for (int r = 0; r < TILE_ROWS; r++) begin
            if (row_q == 8'(r)) begin
                y_start = HALF_W'(r * TILE_H);
                y_end   = (r == TILE_ROWS - 1) ? HALF_W'(LCD_H - 1) : HALF_W'(r * TILE_H + TILE_H - 1);
            end
        end
    end

    assign tile_idx  = 8'(int'(row_q) * TILE_COLS + int'(col_q) + 1);
    assign last_col  = (col_q == 8'(TILE_COLS - 1));
    assign last_tile = last_col && (row_q == 8'(TILE_ROWS - 1));
    assign tile_oor  = (int'(win_if.tile_col_i) >= TILE_COLS) || (int'(win_if.tile_row_i) >= TILE_ROWS);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        col_d   = col_q;
        row_d   = row_q;
        set_x_d = set_x_q;
        set_y_d = set_y_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // abort_i has no meaning here, so a coincident start always wins.
                if (win_if.start_i) begin
                    if (win_if.mode_i == 2'b11 || (win_if.mode_i == 2'b10 && tile_oor)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        mode_d  = win_if.mode_i;
                        col_d   = (win_if.mode_i == 2'b10) ? win_if.tile_col_i : 8'd0;
                        row_d   = (win_if.mode_i == 2'b10) ? win_if.tile_row_i : 8'd0;
                    end
                end
            end
            LOAD: begin
                if (win_if.abort_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = PRESENT;
                    if (mode_q == 2'b00) begin
                        set_x_d = {HALF_W'(0), HALF_W'(LCD_W - 1)};
                        set_y_d = {HALF_W'(0), HALF_W'(LCD_H - 1)};
                        idx_d   = 8'd0;
                    end else begin
                        set_x_d = {x_start, x_end};
                        set_y_d = {y_start, y_end};
                        idx_d   = tile_idx;
                    end
                end
            end
            PRESENT: begin
                if (win_if.abort_i) begin
                    state_d = IDLE;
                end else if (win_if.win_ack_i) begin
                    if (mode_q == 2'b01 && !last_tile) begin
                        state_d = LOAD;
                        col_d   = last_col ? 8'd0 : col_q + 8'd1;
                        row_d   = last_col ? row_q + 8'd1 : row_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            col_q   <= 8'd0;
            row_q   <= 8'd0;
            set_x_q <= '0;
            set_y_q <= '0;
            idx_q   <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            col_q   <= col_d;
            row_q   <= row_d;
            set_x_q <= set_x_d;
            set_y_q <= set_y_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign win_if.win_valid_o = (state_q == PRESENT);
    assign win_if.busy_o      = (state_q != IDLE);
    assign win_if.set_x_o     = set_x_q;
    assign win_if.set_y_o     = set_y_q;
    assign win_if.tile_idx_o  = idx_q;
    assign win_if.done_o      = done_q;
    assign win_if.err_o       = err_q;
endmodule
